rgmii_tx_ddr: RTL

- Transmit-side companion to the generic input DDR capture stage.
- Accepts a GMII-style byte stream (txd/tx_en/tx_er) in the single system clock domain and drives RGMII 4-bit DDR data plus the TX_CTL pin.
- Serializes through an internal generic output-DDR stage.
- Supports 1000 mode (both clock edges, one byte per cycle) and 10/100 mode (nibble per clock-enable slot, same nibble on both edges), and sits between the MAC TX path and the board pins.

---
 rtl/rgmii_tx_ddr.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rgmii_tx_ddr.sv
// rgmii_tx_ddr: GMII byte stream to RGMII 4-bit DDR transmit pins.
//
// Pipeline, per byte or nibble slot:
//   input/hold register -> encode register -> output DDR stage (r1/r2, r2n).
// A byte sampled at posedge N appears on the pins in the high phase after
// posedge N+2. This holds in both 1000 mode and 10/100 mode.
//
// In 10/100 mode a two-state FSM tracks which nibble is on the pins. It only
// looks at mii_select in the LOW phase, so a mode change takes effect at the
// next byte boundary.
//
// Optional feature: define RGMII_TX_CLK_FWD_EN to add the rgmii_tx_clk output.
// That output is driven through the same pipeline as the data.
module rgmii_tx_ddr #(
  parameter int   WIDTH     = 4,
  parameter logic RESET_CTL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mii_select,
  input  logic             clk_en,
  input  logic [7:0]       gmii_txd,
  input  logic             gmii_tx_en,
  input  logic             gmii_tx_er,
  output logic             gmii_ready,
  output logic [WIDTH-1:0] rgmii_txd,
  output logic             rgmii_tx_ctl
`ifdef RGMII_TX_CLK_FWD_EN
  ,
  output logic             rgmii_tx_clk
`endif
);

  if (WIDTH != 4) begin : g_bad_width
    $error("rgmii_tx_ddr: only WIDTH=4 is supported");
  end

  // Lane word: data nibble, ctl bit at [WIDTH], and optionally the forwarded clock on top.
`ifdef RGMII_TX_CLK_FWD_EN
  localparam int LW = WIDTH + 2;
`else
  localparam int LW = WIDTH + 1;
`endif

  typedef enum logic [0:0] {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_e;

  phase_e           phase_q, phase_d;
  logic             accept_s, adv_hi_s;
  logic [7:0]       txd_q;
  logic             en_q, er_q, hi_sel_q, mii_q;
  logic [WIDTH-1:0] nib_s;
  logic [LW-1:0]    enc_rise_d, enc_fall_d, enc_rise_q, enc_fall_q;
  logic [LW-1:0]    r1_q, r2_q, r2n_q, pin_s;

  // Nibble-phase FSM: decide whether this cycle accepts a byte or advances to the high nibble.
  always_comb begin
    phase_d  = phase_q;
    accept_s = 1'b0;
    adv_hi_s = 1'b0;
    case (phase_q)
      PH_LOW: begin
        if (mii_select) begin
          if (clk_en) begin
            accept_s = 1'b1;
            phase_d  = PH_HIGH;
          end else begin
            phase_d  = PH_LOW;
          end
        end else begin
          accept_s = 1'b1;
          phase_d  = PH_LOW;
        end
      end
      PH_HIGH: begin
        if (clk_en) begin
          adv_hi_s = 1'b1;
          phase_d  = PH_LOW;
        end else begin
          phase_d  = PH_HIGH;
        end
      end
      default: phase_d = PH_LOW;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= PH_LOW;
    else     phase_q <= phase_d;
  end

  // Input/hold register: capture the accepted byte, or switch to its high nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_q    <= 8'h00;
      en_q     <= 1'b0;
      er_q     <= 1'b0;
      hi_sel_q <= 1'b0;
      mii_q    <= 1'b0;
    end else if (accept_s) begin
      txd_q    <= gmii_txd;
      en_q     <= gmii_tx_en;
      er_q     <= gmii_tx_er;
      hi_sel_q <= 1'b0;
      mii_q    <= mii_select;
    end else if (adv_hi_s) begin
      hi_sel_q <= 1'b1;
    end
  end

  // Encode rising/falling lane words. Data is zeroed outside a frame; ctl carries en and en^er.
  always_comb begin
    nib_s      = hi_sel_q ? txd_q[7:4] : txd_q[3:0];
    enc_rise_d = '0;
    enc_fall_d = '0;
    if (!en_q) begin
      enc_rise_d[WIDTH-1:0] = '0;
      enc_fall_d[WIDTH-1:0] = '0;
    end else if (mii_q) begin
      enc_rise_d[WIDTH-1:0] = nib_s;
      enc_fall_d[WIDTH-1:0] = nib_s;
    end else begin
      enc_rise_d[WIDTH-1:0] = txd_q[3:0];
      enc_fall_d[WIDTH-1:0] = txd_q[7:4];
    end
    enc_rise_d[WIDTH] = en_q;
    enc_fall_d[WIDTH] = en_q ^ er_q;
`ifdef RGMII_TX_CLK_FWD_EN
    if (mii_q) begin
      enc_rise_d[LW-1] = ~hi_sel_q;
      enc_fall_d[LW-1] = ~hi_sel_q;
    end else begin
      enc_rise_d[LW-1] = 1'b1;
      enc_fall_d[LW-1] = 1'b0;
    end
`endif
  end

  // Encode register plus the posedge half of the DDR stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_rise_q <= '0;
      enc_fall_q <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
    end else begin
      enc_rise_q <= enc_rise_d;
      enc_fall_q <= enc_fall_d;
      r1_q       <= enc_rise_q;
      r2_q       <= enc_fall_q;
    end
  end

  // Negedge half of the DDR stage: the falling-edge word is retimed so it is stable while clk is low.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) r2n_q <= '0;
    else     r2n_q <= r2_q;
  end

  // Pin mux: r1 while clk is high, r2n while low. Reset forces the pin values immediately.
  always_comb begin
    pin_s      = clk ? r1_q : r2n_q;
    gmii_ready = accept_s & ~rst;
    if (rst) begin
      rgmii_txd    = '0;
      rgmii_tx_ctl = RESET_CTL;
    end else begin
      rgmii_txd    = pin_s[WIDTH-1:0];
      rgmii_tx_ctl = pin_s[WIDTH];
    end
`ifdef RGMII_TX_CLK_FWD_EN
    if (rst) rgmii_tx_clk = 1'b0;
    else     rgmii_tx_clk = pin_s[LW-1];
`endif
  end

endmodule
